// File: rtl/fpu_pkg.sv
// Shared FPU types: add-class opcodes, issue-stage states and sign-bit helpers.
package fpu_pkg;

  typedef enum logic [1:0] {
    FADD = 2'd0,
    FSUB = 2'd1,
    FNEG = 2'd2,
    FABS = 2'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fadd_issue_state_e;

  localparam int SIGN_BIT = 31;

  function automatic logic [31:0] flip_sign(input logic [31:0] x);
    return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
  endfunction

  function automatic logic [31:0] clear_sign(input logic [31:0] x);
    return {1'b0, x[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fadd_issue.sv
// Issue/collect stage in front of the single-precision adder: registers operands,
// waits for the adder (with a watchdog), bypasses sign-only ops, holds the tagged result.
module fadd_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  output logic             fadd_ready,
  input  logic             fadd_valid,
  input  logic [31:0]      fadd_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic [31:0]      op_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  fadd_issue_state_e state_r;
  logic [WD_W-1:0]   wdog_r;

  // Handshake flags are kept as flops that always mirror state_r, so every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wdog_r     <= '0;
      req_ready  <= 1'b1;
      fadd_x1    <= 32'd0;
      fadd_x2    <= 32'd0;
      fadd_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_y     <= 32'd0;
      resp_tag   <= '0;
      resp_err   <= 1'b0;
      op_count   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            resp_tag  <= req_tag;
            req_ready <= 1'b0;
            case (fpu_op_e'(req_op))
              FADD, FSUB: begin
                fadd_x1    <= req_a;
                fadd_x2    <= (fpu_op_e'(req_op) == FSUB) ? flip_sign(req_b) : req_b;
                fadd_ready <= 1'b1;
                wdog_r     <= '0;
                state_r    <= EXEC;
              end
              FNEG, FABS: begin
                resp_y     <= (fpu_op_e'(req_op) == FNEG) ? flip_sign(req_a) : clear_sign(req_a);
                resp_err   <= 1'b0;
                resp_valid <= 1'b1;
                state_r    <= RESP;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // A result arriving on the expiry edge takes priority over the timeout.
          if (fadd_valid) begin
            resp_y     <= fadd_y;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            fadd_ready <= 1'b0;
            state_r    <= RESP;
          end else if (wdog_r == WD_LAST) begin
            resp_y     <= 32'd0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            fadd_ready <= 1'b0;
            state_r    <= RESP;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 32'd1;
            req_ready  <= 1'b1;
            state_r    <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          fadd_ready <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
